// File: rtl/tdc_interval_stats.sv
// Windowed min/max/mean statistics over the interval field of successive TDC results,
// plus skipped-measurement and timeout counters for register readback.
module tdc_interval_stats #(
    parameter int unsigned WINDOW_LOG2    = 4,
    parameter int unsigned INTERVAL_WIDTH = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [31:0]               tdc_data,
    input  logic                      clear,
    output logic [INTERVAL_WIDTH-1:0] stat_min,
    output logic [INTERVAL_WIDTH-1:0] stat_max,
    output logic [INTERVAL_WIDTH-1:0] stat_mean,
    output logic                      stat_valid,
    output logic [15:0]               window_count,
    output logic [15:0]               missed_count,
    output logic [15:0]               timeout_count
);

    localparam int unsigned PW = 32 - INTERVAL_WIDTH;
    localparam int unsigned SW = INTERVAL_WIDTH + WINDOW_LOG2;
    localparam int unsigned NW = WINDOW_LOG2 + 1;
    localparam logic [NW-1:0] N_LAST = NW'((1 << WINDOW_LOG2) - 1);
    localparam logic [INTERVAL_WIDTH-1:0] IV_ONES = '1;

    typedef enum logic [1:0] {
        S_PRIME,
        S_RUN,
        S_PUBLISH
    } state_t;

    state_t state, state_nxt;

    logic [31:0]               d1;
    logic [PW-1:0]             last_pass;
    logic [NW-1:0]             acc_n;
    logic [SW-1:0]             acc_sum;
    logic [INTERVAL_WIDTH-1:0] acc_min;
    logic [INTERVAL_WIDTH-1:0] acc_max;

    logic [PW-1:0]             d1_pass;
    logic [INTERVAL_WIDTH-1:0] d1_iv;
    logic                      primed;
    logic                      new_result;
    logic                      is_timeout;
    logic                      take_sample;
    logic                      close;
    logic [PW-1:0]             gap;
    logic [32:0]               missed_sum;
    logic [SW-1:0]             sum_next;
    logic [INTERVAL_WIDTH-1:0] min_next;
    logic [INTERVAL_WIDTH-1:0] max_next;

    assign d1_pass     = d1[31:INTERVAL_WIDTH];
    assign d1_iv       = d1[INTERVAL_WIDTH-1:0];
    assign primed      = (state != S_PRIME);
    assign new_result  = primed && (d1_pass != last_pass);
    assign is_timeout  = (d1_iv == IV_ONES);
    assign take_sample = new_result && !clear && !is_timeout;
    assign close       = take_sample && (acc_n == N_LAST);
    // Modular subtraction makes the 0xFFFFF -> 0 wrap a single step with no gap.
    assign gap         = d1_pass - last_pass - PW'(1);
    assign missed_sum  = 33'(missed_count) + 33'(gap);
    assign sum_next    = acc_sum + SW'(d1_iv);
    assign min_next    = (d1_iv < acc_min) ? d1_iv : acc_min;
    assign max_next    = (d1_iv > acc_max) ? d1_iv : acc_max;
    assign stat_valid  = (state == S_PUBLISH);

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_PRIME:   state_nxt = S_RUN;
            S_RUN,
            S_PUBLISH: state_nxt = close ? S_PUBLISH : S_RUN;
            default:   state_nxt = S_PRIME;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_PRIME;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1            <= '0;
            last_pass     <= '0;
            acc_n         <= '0;
            acc_sum       <= '0;
            acc_min       <= '1;
            acc_max       <= '0;
            stat_min      <= '1;
            stat_max      <= '0;
            stat_mean     <= '0;
            window_count  <= '0;
            missed_count  <= '0;
            timeout_count <= '0;
        end else begin
            d1 <= tdc_data;

            // The TDC word is stale after reset, so its pass count becomes the baseline.
            if (!primed)         last_pass <= tdc_data[31:INTERVAL_WIDTH];
            else if (new_result) last_pass <= d1_pass;

            if (clear) begin
                acc_n         <= '0;
                acc_sum       <= '0;
                acc_min       <= '1;
                acc_max       <= '0;
                window_count  <= '0;
                missed_count  <= '0;
                timeout_count <= '0;
            end else begin
                if (new_result) begin
                    missed_count <= (missed_sum > 33'h0_FFFF) ? 16'hFFFF : missed_sum[15:0];
                    if (is_timeout && (timeout_count != 16'hFFFF))
                        timeout_count <= timeout_count + 16'd1;
                end

                if (close) begin
                    stat_min     <= min_next;
                    stat_max     <= max_next;
                    stat_mean    <= INTERVAL_WIDTH'(sum_next >> WINDOW_LOG2);
                    window_count <= window_count + 16'd1;
                    acc_n        <= '0;
                    acc_sum      <= '0;
                    acc_min      <= '1;
                    acc_max      <= '0;
                end else if (take_sample) begin
                    acc_n   <= acc_n + NW'(1);
                    acc_sum <= sum_next;
                    acc_min <= min_next;
                    acc_max <= max_next;
                end
            end
        end
    end

endmodule

// File: doc/tdc_interval_stats.md
Name: tdc_interval_stats

Overview:
- Downstream consumer of the simple TDC result word, in the same clock domain as the TDC.
- Detects each new TDC measurement by watching the 20-bit pass-count field change, and discards TDC timeouts.
- Accumulates min/max/sum over a window of 2^WINDOW_LOG2 valid intervals, then publishes min, max and mean with a one-cycle strobe.
- Also counts skipped measurements (pass-count jumps) and timeouts, for register readback by the control processor.

Parameters:
- WINDOW_LOG2, 4, log2 of the number of valid intervals per published window; legal range 0..8.
- INTERVAL_WIDTH, 12, width of the interval field in tdc_data[INTERVAL_WIDTH-1:0]; pass-count field is tdc_data[31:INTERVAL_WIDTH].

Ports:
- clk  in  1  system clock, same clock as the TDC.
- rst_n  in  1  asynchronous active-low reset.
- tdc_data  in  32  TDC result word: {pass_count, interval}.
- clear  in  1  synchronous pulse: abandon the current window and zero the counters.
- stat_min  out  INTERVAL_WIDTH  minimum interval of the last window.
- stat_max  out  INTERVAL_WIDTH  maximum interval of the last window.
- stat_mean  out  INTERVAL_WIDTH  floor(sum/2^WINDOW_LOG2) of the last window.
- stat_valid  out  1  one-cycle strobe when stat_* are updated.
- window_count  out  16  number of windows published; wraps.
- missed_count  out  16  total skipped measurements; saturates at 0xFFFF.
- timeout_count  out  16  total timeout results; saturates at 0xFFFF.

Behaviour:
Reset and interface:
- Reset is asynchronous and active-low on rst_n; all logic is clocked by clk, one clock, no CDC.
- On reset, all outputs go to 0, except stat_min, which resets to all-ones.
- Internal state on reset: primed=0, accumulators cleared, baseline pass count = 0.

Input stage:
- tdc_data is registered once (d1).
- A new result is detected when d1.pass != last_pass and primed=1.
- When primed=0, the first clock after reset latches last_pass = d1.pass, sets primed=1 and records no sample (the TDC output is stale after reset).

Per new result, processed in the cycle after d1 captures it:
- last_pass <= d1.pass.
- gap = (d1.pass - last_pass - 1) mod 2^20; missed_count += gap, saturating.
- If interval == all-ones, it is a timeout: timeout_count += 1 (saturating), and there is no accumulator update.
- Otherwise it is a valid sample:
  - acc_n += 1.
  - acc_sum += interval; acc_sum width is INTERVAL_WIDTH+WINDOW_LOG2 and never overflows.
  - acc_min = min(acc_min, interval); acc_max = max(acc_max, interval).

Window close:
- The window closes when the valid sample makes acc_n reach 2^WINDOW_LOG2.
- In the same cycle:
  - stat_min/max take the values including this sample.
  - stat_mean = (acc_sum + interval) >> WINDOW_LOG2.
  - stat_valid = 1; window_count += 1.
  - Accumulators reinit: n=0, sum=0, min=all-ones, max=0.
- Latency: tdc_data change at edge N gives stat_valid high in the cycle after edge N+2.
- stat_* hold their value until the next publish or reset.

FSM (3 states):
- PRIME: -> RUN after the first clock.
- RUN: on window close -> PUBLISH.
- PUBLISH: lasts one cycle, strobe asserted; always -> RUN.
- A new result arriving while in PUBLISH is processed normally; the accumulators are already reinitialised, so no result is lost. The TDC dead time makes back-to-back results impossible, but the design tolerates them.

clear:
- Zeros missed_count, timeout_count, window_count and the accumulators.
- stat_min/max/mean keep their values.
- primed stays set.
- If clear coincides with a new result: clear wins, the sample is discarded, and last_pass still updates so no false miss is counted.

Edge cases:
- Pass-count wrap from 0xFFFFF to 0x00000 is a normal single step, gap = 0.
- Interval value 0 is a valid sample.
- Reset mid-window discards the partial window.

Test Plan:
- Reset, hold tdc_data=0x00005_010, release -> no stat_valid, missed=0; proves the baseline is latched, not counted.
- WINDOW_LOG2=2; pass 6..9 with intervals 0x010, 0x020, 0x030, 0x041 -> stat_valid once, min=0x010, max=0x041, mean=0x028, window_count=1, exactly 3 cycles after the last change.
- Interval 0xFFF at pass 10, then pass 13 interval 0x005 -> timeout_count=1, missed_count=2, acc_n=1.
- Pass 0xFFFFF -> 0x00000 with valid intervals -> missed_count unchanged, samples accumulated.
- clear in the same cycle a new result is detected -> counters 0, sample dropped, next sequential pass gives missed=0.
- Assert rst_n low mid-window with 3 samples -> outputs at reset values immediately (asynchronous); the next window needs a full 4 samples after re-priming.
